// File: rtl/memory_io_ctrl_v2.sv
// ============================================================================
//  Module   : memory_io_ctrl_v2
//  Purpose  : Data-side router between the load/store unit and the data RAM,
//             with a small MMIO window of output and input ports at the top
//             of the word address space. All reads take one cycle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_io_ctrl_v2 #(
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_OUT    = 2,
    parameter int                    NUM_IN     = 2,
    parameter logic [DATA_WIDTH-1:0] OUT_RST    = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    input  logic                           req_we,
    input  logic [ADDR_WIDTH-1:0]          req_addr,
    input  logic [DATA_WIDTH-1:0]          req_wdata,
    input  logic [DATA_WIDTH/8-1:0]        req_be,
    output logic                           rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           mem_wr_en,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic [DATA_WIDTH/8-1:0]        mem_be,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   port_in,
    output logic [NUM_OUT*DATA_WIDTH-1:0]  port_out,
    output logic [NUM_OUT-1:0]             port_out_stb
);

    localparam int                    BE_W        = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] c_MAX_ADDR  = '1;
    localparam logic [ADDR_WIDTH-1:0] c_MMIO_SPAN = ADDR_WIDTH'(NUM_OUT + NUM_IN - 1);
    localparam logic [ADDR_WIDTH-1:0] c_MMIO_BASE = c_MAX_ADDR - c_MMIO_SPAN;
    localparam logic [ADDR_WIDTH-1:0] c_NUM_OUT   = ADDR_WIDTH'(NUM_OUT);

    logic [ADDR_WIDTH-1:0]          w_off;
    logic                           w_mmio_hit;
    logic                           w_ram_hit;
    logic                           w_rd;
    logic                           w_wr_out;
    logic [DATA_WIDTH-1:0]          w_mmio_rdata;
    logic [NUM_OUT*DATA_WIDTH-1:0]  w_port_out;

    logic [NUM_IN*DATA_WIDTH-1:0]   r_sync1;
    logic [NUM_IN*DATA_WIDTH-1:0]   r_sync2;
    logic                           r_rsp_valid;
    logic                           r_rsp_ram;
    logic [DATA_WIDTH-1:0]          r_mmio_rdata;

    // Distance from the top of the address space; MMIO ports are indexed by it.
    assign w_off      = c_MAX_ADDR - req_addr;
    assign w_mmio_hit = (req_addr >= c_MMIO_BASE);
    assign w_ram_hit  = ~w_mmio_hit;
    assign w_rd       = req_valid & ~req_we;
    assign w_wr_out   = req_valid & req_we & w_mmio_hit & (w_off < c_NUM_OUT);

    assign mem_wr_en = req_valid &  req_we & w_ram_hit;
    assign mem_rd_en = req_valid & ~req_we & w_ram_hit;
    assign mem_addr  = req_addr;
    assign mem_wdata = req_wdata;
    assign mem_be    = req_be;

    always_comb begin
        w_mmio_rdata = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (w_off == ADDR_WIDTH'(k))
                w_mmio_rdata = w_port_out[k*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int k = 0; k < NUM_IN; k++) begin
            if (w_off == ADDR_WIDTH'(NUM_OUT + k))
                w_mmio_rdata = r_sync2[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
        logic                  w_wr_hit;
        logic [DATA_WIDTH-1:0] r_q;
        logic                  r_stb;

        assign w_wr_hit = w_wr_out & (w_off == ADDR_WIDTH'(k));

        // Strobe fires even with no byte enables set, so software can pulse a port.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q   <= OUT_RST;
                r_stb <= 1'b0;
            end else begin
                r_stb <= w_wr_hit;
                for (int b = 0; b < BE_W; b++) begin
                    if (w_wr_hit && req_be[b])
                        r_q[b*8 +: 8] <= req_wdata[b*8 +: 8];
                end
            end
        end

        assign w_port_out[k*DATA_WIDTH +: DATA_WIDTH] = r_q;
        assign port_out_stb[k]                        = r_stb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= port_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_ram    <= 1'b0;
            r_mmio_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            r_rsp_ram   <= w_rd & w_ram_hit;
            if (w_rd)
                r_mmio_rdata <= w_mmio_rdata;
        end
    end

    assign port_out  = w_port_out;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_ram ? mem_rdata : r_mmio_rdata;

endmodule

`default_nettype wire

// File: tb/tb_memory_io_ctrl_v2.sv
// ============================================================================
//  Module   : tb_memory_io_ctrl_v2
//  Purpose  : Directed self-checking bench for memory_io_ctrl_v2 with a
//             behavioural synchronous RAM attached to the mem_* port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_io_ctrl_v2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic [63:0] port_in;
    logic [63:0] port_out;
    logic [1:0]  port_out_stb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ram [0:1023];

    memory_io_ctrl_v2 u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_be       (req_be),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_rdata    (mem_rdata),
        .port_in      (port_in),
        .port_out     (port_out),
        .port_out_stb (port_out_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        port_in   = '0;
        mem_rdata = '0;
        ram[10'h010] = 32'h1010_AAAA;
        ram[10'h011] = 32'h1111_BBBB;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step();

        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        chk("rst_port_out", port_out, 64'd0);
        chk("rst_stb", {62'd0, port_out_stb}, 64'd0);

        // Output port 0 partial write over an all-ones value
        req(1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF);
        step();
        chk("p0_full_write", port_out, 64'h0000_0000_FFFF_FFFF);
        req(1'b1, 10'h3FF, 32'hA5A5_1234, 4'b0011);
        chk("p0_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
        step();
        chk("p0_partial", port_out, 64'h0000_0000_FFFF_1234);
        chk("p0_stb_on", {62'd0, port_out_stb}, 64'd1);
        step();
        chk("p0_stb_off", {62'd0, port_out_stb}, 64'd0);

        // be=0 strobes without changing data
        req(1'b1, 10'h3FE, 32'h5555_5555, 4'b0000);
        step();
        chk("p1_be0_stb", {62'd0, port_out_stb}, 64'd2);
        chk("p1_be0_data", port_out, 64'h0000_0000_FFFF_1234);
        req(1'b1, 10'h3FE, 32'h1122_3344, 4'hF);
        step();
        chk("p1_write", port_out, 64'h1122_3344_FFFF_1234);

        // Synchronised input ports
        port_in = {32'hDEAD_BEEF, 32'h0BAD_F00D};
        repeat (3) step();
        req(1'b0, 10'h3FC, 32'd0, 4'h0);
        chk("in1_mem_rd_en", {63'd0, mem_rd_en}, 64'd0);
        step();
        chk("in1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("in1_data", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);

        // Back-to-back RAM / port / RAM reads
        req(1'b0, 10'h010, 32'd0, 4'h0);
        chk("rd0_mem_rd_en", {63'd0, mem_rd_en}, 64'd1);
        step();
        chk("rd0_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd0_data", {32'd0, rsp_rdata}, 64'h1010_AAAA);
        req(1'b0, 10'h3FE, 32'd0, 4'h0);
        step();
        chk("rd1_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd1_data", {32'd0, rsp_rdata}, 64'h1122_3344);
        req(1'b0, 10'h011, 32'd0, 4'h0);
        step();
        chk("rd2_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rd2_data", {32'd0, rsp_rdata}, 64'h1111_BBBB);
        step();
        chk("idle_no_rsp", {63'd0, rsp_valid}, 64'd0);

        // Writes to an input port are ignored; just below the window is RAM
        req(1'b1, 10'h3FD, 32'h7777_7777, 4'hF);
        chk("inwr_mem_wr_en", {63'd0, mem_wr_en}, 64'd0);
        step();
        chk("inwr_stb", {62'd0, port_out_stb}, 64'd0);
        chk("inwr_ports", port_out, 64'h1122_3344_FFFF_1234);
        chk("wr_no_rsp", {63'd0, rsp_valid}, 64'd0);
        req(1'b0, 10'h3FD, 32'd0, 4'h0);
        step();
        chk("in0_data", {32'd0, rsp_rdata}, 64'h0BAD_F00D);
        req(1'b1, 10'h3FB, 32'hCAFE_0001, 4'hF);
        chk("ram_top_wr_en", {63'd0, mem_wr_en}, 64'd1);
        step();
        chk("ram_top_stb", {62'd0, port_out_stb}, 64'd0);
        req(1'b0, 10'h3FB, 32'd0, 4'h0);
        step();
        chk("ram_top_rd", {32'd0, rsp_rdata}, 64'hCAFE_0001);

        // Reset asserted while a read is in flight
        req(1'b0, 10'h010, 32'd0, 4'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("mid_rst_ports", port_out, 64'd0);
        chk("mid_rst_rdata", {32'd0, rsp_rdata}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("post_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("post_rst_stb", {62'd0, port_out_stb}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
